// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared fetch packet types for the instruction fetch queue
//
// Purpose: defines the lane count and the packed fetch packet that one
// queue slot holds (packet PC, four instruction words, per-lane hit mask).
package fetch_pkg;

   localparam int FETCH_WIDTH = 4;

   typedef struct packed {
      logic [31:0]       pc;
      logic [3:0][31:0]  inst;
      logic [3:0]        mask;
   } fetch_packet_t;

endpackage

// File: rtl/fetch_queue_ram.sv
// rtl/fetch_queue_ram.sv - packet storage array for the instruction fetch queue
//
// Purpose: DEPTH x fetch_packet_t register array, one synchronous write
// port and one asynchronous read port. Contents are not reset.
// Ports:
//   clk      clock
//   we_i     write enable (slot written at the rising edge)
//   waddr_i  write slot index
//   wdata_i  packet to write
//   raddr_i  read slot index
//   rdata_o  packet at raddr_i, combinational
module fetch_queue_ram
   import fetch_pkg::*;
#(
   parameter int DEPTH = 8
)(
   input  logic                     clk,
   input  logic                     we_i,
   input  logic [$clog2(DEPTH)-1:0] waddr_i,
   input  fetch_packet_t            wdata_i,
   input  logic [$clog2(DEPTH)-1:0] raddr_i,
   output fetch_packet_t            rdata_o
);

   fetch_packet_t mem_q [DEPTH];

   always_ff @(posedge clk) begin
      if (we_i) begin
         mem_q[waddr_i] <= wdata_i;
      end
   end

   assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/inst_fetch_queue.sv
// rtl/inst_fetch_queue.sv - decoupling FIFO of fetch packets between ICache and decode
//
// Purpose: buffers one 4-lane fetch packet per cycle and presents the head
// packet to decode under valid/ready; flush empties the queue.
// Optional feature macro: FETCH_QUEUE_BYPASS_EN (empty-queue pass-through,
// 0-cycle latency when decode is ready).
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   flush               redirect; drops all buffered packets and any concurrent input
//   in_valid/in_ready   input handshake; in_ready depends on occupancy only
//   in_pc/in_inst/in_mask  incoming packet (mask all-zero: accepted, not stored)
//   out_valid/out_ready output handshake to decode
//   out_pc/out_inst/out_mask  head packet (don't-care while out_valid is 0)
//   count               occupancy in packets
module inst_fetch_queue
   import fetch_pkg::fetch_packet_t;
#(
   parameter int DEPTH       = 8,
   parameter int FETCH_WIDTH = 4
)(
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       flush,
   input  logic                       in_valid,
   input  logic [31:0]                in_pc,
   input  logic [31:0]                in_inst [FETCH_WIDTH-1:0],
   input  logic                       in_mask [FETCH_WIDTH-1:0],
   output logic                       in_ready,
   output logic                       out_valid,
   output logic [31:0]                out_pc,
   output logic [31:0]                out_inst [FETCH_WIDTH-1:0],
   output logic [FETCH_WIDTH-1:0]     out_mask,
   input  logic                       out_ready,
   output logic [$clog2(DEPTH+1)-1:0] count
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH+1);

   logic [PW-1:0] wptr_q, wptr_d;
   logic [PW-1:0] rptr_q, rptr_d;
   logic [CW-1:0] count_q, count_d;

   fetch_packet_t in_pkt, rd_pkt, head_pkt;
   logic          in_any;
   logic          stored_valid;
   logic          byp_valid;
   logic          byp_take;
   logic          push;
   logic          pop;

   always_comb begin
      in_pkt    = '0;
      in_pkt.pc = in_pc;
      in_any    = 1'b0;
      for (int i = 0; i < FETCH_WIDTH; i++) begin
         in_pkt.inst[i] = in_inst[i];
         in_pkt.mask[i] = in_mask[i];
         in_any         = in_any | in_mask[i];
      end
   end

   assign stored_valid = (count_q != '0);
   // Occupancy-only ready: a pop in a full cycle frees the slot next cycle.
   assign in_ready     = (count_q != CW'(DEPTH));

`ifdef FETCH_QUEUE_BYPASS_EN
   assign byp_valid = ~stored_valid & in_valid & in_any & ~flush;
   assign byp_take  = byp_valid & out_ready;
   assign head_pkt  = byp_valid ? in_pkt : rd_pkt;
`else
   assign byp_valid = 1'b0;
   assign byp_take  = 1'b0;
   assign head_pkt  = rd_pkt;
`endif

   assign out_valid = stored_valid | byp_valid;
   // A bypassed packet consumed this cycle is never written.
   assign push = in_valid & in_ready & ~flush & in_any & ~byp_take;
   assign pop  = stored_valid & out_ready & ~flush;

   always_comb begin
      wptr_d  = wptr_q;
      rptr_d  = rptr_q;
      count_d = count_q;
      if (push) wptr_d = wptr_q + PW'(1);
      if (pop)  rptr_d = rptr_q + PW'(1);
      case ({push, pop})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
      if (flush) begin
         wptr_d  = '0;
         rptr_d  = '0;
         count_d = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         count_q <= '0;
      end else begin
         wptr_q  <= wptr_d;
         rptr_q  <= rptr_d;
         count_q <= count_d;
      end
   end

   fetch_queue_ram #(
      .DEPTH (DEPTH)
   ) u_ram (
      .clk     (clk),
      .we_i    (push),
      .waddr_i (wptr_q),
      .wdata_i (in_pkt),
      .raddr_i (rptr_q),
      .rdata_o (rd_pkt)
   );

   assign count    = count_q;
   assign out_pc   = head_pkt.pc;
   assign out_mask = head_pkt.mask;

   always_comb begin
      for (int i = 0; i < FETCH_WIDTH; i++) begin
         out_inst[i] = head_pkt.inst[i];
      end
   end

endmodule
